// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle for the multi-cycle execute unit.
// A transfer happens on a rising edge where valid & ready are both high; the
// producer holds its payload stable while valid is high and ready is low.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output flush, in_valid, alu_ctl, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  flush, in_valid, alu_ctl, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_mc.sv
// rv32e EX-stage ALU: single-cycle arithmetic/logic/compare, iterative
// 1-bit-per-cycle shifter for SLL/SRL/SRA, ready/valid on both sides.
module alu_exec_mc #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_COPYB = 4'b1000;
  localparam logic [3:0] OP_COPYB2 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic                out_valid_q;
  logic                zero_q;
  logic [XLEN-1:0]     result_q;
  logic [XLEN-1:0]     sh_val;
  logic [XLEN-1:0]     sh_next;
  logic [SHAMT_W-1:0]  sh_cnt;
  logic                sh_left;
  logic                sh_arith;

  logic [XLEN-1:0]     alu_res;
  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;
  logic                slt_bit;
  logic                sltu_bit;
  logic                in_ready;
  logic                accept;

  assign shamt    = bus.b[SHAMT_W-1:0];
  assign slt_bit  = $signed(bus.a) < $signed(bus.b);
  assign sltu_bit = bus.a < bus.b;
  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  // Shift opcodes return a unchanged here; that is the shamt==0 result.
  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    case (bus.alu_ctl)
      OP_AND:    alu_res = bus.a & bus.b;
      OP_OR:     alu_res = bus.a | bus.b;
      OP_XOR:    alu_res = bus.a ^ bus.b;
      OP_ADD:    alu_res = bus.a + bus.b;
      OP_SUB:    alu_res = bus.a - bus.b;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = bus.a;
      end
      OP_COPYB, OP_COPYB2: alu_res = bus.b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    sh_next = sh_val;
    if (sh_left) sh_next = {sh_val[XLEN-2:0], 1'b0};
    else         sh_next = {sh_arith & sh_val[XLEN-1], sh_val[XLEN-1:1]};
  end

  // result/zero only update on entry to DONE, so partial shifts never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      sh_val      <= '0;
      sh_cnt      <= '0;
      sh_left     <= 1'b0;
      sh_arith    <= 1'b0;
    end else if (bus.flush) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else if (state == ST_SHIFT) begin
      sh_val <= sh_next;
      sh_cnt <= sh_cnt - SHAMT_W'(1);
      if (sh_cnt == SHAMT_W'(1)) begin
        state       <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= sh_next;
        zero_q      <= (sh_next == '0);
      end
    end else if (accept) begin
      if (is_shift && (shamt != '0)) begin
        state       <= ST_SHIFT;
        out_valid_q <= 1'b0;
        sh_val      <= bus.a;
        sh_cnt      <= shamt;
        sh_left     <= (bus.alu_ctl == OP_SLL);
        sh_arith    <= (bus.alu_ctl == OP_SRA);
      end else begin
        state       <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        zero_q      <= (alu_res == '0);
      end
    end else if ((state == ST_DONE) && bus.out_ready) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed bench for alu_exec_mc: single-cycle ops, iterative shifts,
// back-to-back, backpressure, flush and asynchronous reset mid-shift.
module tb_alu_exec_mc;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    logic [7:0]  lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] exp_q[$];

  alu_exec_if #(.XLEN(32)) bus();

  alu_exec_mc #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  vec_t arith_v[14] = '{
    '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 8'd1},
    '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 8'd1},
    '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 8'd1},
    '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 8'd1},
    '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 8'd1},
    '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 8'd1},
    '{OP_AND,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 8'd1},
    '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 8'd1},
    '{OP_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 8'd1},
    '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 8'd1},
    '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 8'd1},
    '{4'b1000, 32'h0000DEAD, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 8'd1},
    '{4'b1111, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 8'd1},
    '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 8'd1}
  };

  vec_t shift_v[7] = '{
    '{OP_SRL, 32'hF0000000, 32'hFFFFFFE4, 32'h0F000000, 1'b0, 8'd5},
    '{OP_SLL, 32'h00000003, 32'h00000020, 32'h00000003, 1'b0, 8'd1},
    '{OP_SLL, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 8'd2},
    '{OP_SRA, 32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 8'd3},
    '{OP_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 8'd32},
    '{OP_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 8'd32},
    '{OP_SRA, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 8'd2}
  };

  // driver tasks; all called at a falling edge and return at a falling edge
  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = 4'b0000;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b0;
  endtask

  task automatic issue(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv);
    bus.alu_ctl  = ctl;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < max_cyc) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", bus.result); end
    checks++;
    if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", bus.zero); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_arith();
    foreach (arith_v[i]) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready got %b want 1", i, bus.in_ready); end
      issue(arith_v[i].ctl, arith_v[i].a, arith_v[i].b);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_latency out_valid got %b want 1", i, bus.out_valid); end
      checks++;
      if (bus.result !== arith_v[i].exp) begin errors++; $display("FAIL arith%0d_result got %h want %h", i, bus.result, arith_v[i].exp); end
      checks++;
      if (bus.zero !== arith_v[i].ez) begin errors++; $display("FAIL arith%0d_zero got %b want %b", i, bus.zero, arith_v[i].ez); end
      retire();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arith_drain out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_sra_long();
    int bad;
    bus.alu_ctl  = OP_SRA;
    bus.a        = 32'h80000000;
    bus.b        = 32'h0000001F;
    bus.in_valid = 1'b1;
    @(negedge clk);
    // a different op kept valid during the shift must be ignored
    bus.alu_ctl = OP_ADD;
    bus.a       = 32'h00000001;
    bus.b       = 32'h00000001;
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL sra_state got %0d want 1", dbg_state); end
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sra_busy bad_cycles got %0d want 0", bad); end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sra_latency out_valid got %b want 1", bus.out_valid); end
    checks++;
    if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sra_result got %h want ffffffff", bus.result); end
    checks++;
    if (bus.zero !== 1'b0) begin errors++; $display("FAIL sra_zero got %b want 0", bus.zero); end
    bus.in_valid = 1'b0;
    retire();
  endtask

  task automatic test_shift();
    int lat;
    foreach (shift_v[i]) begin
      issue(shift_v[i].ctl, shift_v[i].a, shift_v[i].b);
      wait_valid(40, lat);
      checks++;
      if (lat != int'(shift_v[i].lat) || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL shift%0d_latency got %0d want %0d", i, lat, shift_v[i].lat);
      end
      checks++;
      if (bus.result !== shift_v[i].exp) begin errors++; $display("FAIL shift%0d_result got %h want %h", i, bus.result, shift_v[i].exp); end
      checks++;
      if (bus.zero !== shift_v[i].ez) begin errors++; $display("FAIL shift%0d_zero got %b want %b", i, bus.zero, shift_v[i].ez); end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_a[3] = '{32'h00000001, 32'h0000000A, 32'hFFFFFFFF};
    logic [31:0] op_b[3] = '{32'h00000002, 32'h00000014, 32'hFFFFFFFF};
    logic [31:0] res_e[3] = '{32'h00000003, 32'h0000001E, 32'hFFFFFFFE};
    logic [31:0] exp_v;
    int got = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid === 1'b1) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra result got %h want none", bus.result);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.result !== exp_v) begin errors++; $display("FAIL b2b_result got %h want %h", bus.result, exp_v); end
        end
      end
      if (k < 3) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d got %b want 1", k, bus.in_ready); end
        bus.alu_ctl  = OP_ADD;
        bus.a        = op_a[k];
        bus.b        = op_b[k];
        bus.in_valid = 1'b1;
        exp_q.push_back(res_e[k]);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++;
    if (got != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d want 3 (left %0d)", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue(OP_XOR, 32'hA5A5A5A5, 32'hFFFFFFFF);
    bus.alu_ctl  = OP_ADD;
    bus.a        = 32'h00000000;
    bus.b        = 32'h00000000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h5A5A5A5A || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable bad_cycles got %0d want 0", bad); end
    checks++;
    if (bus.result !== 32'h5A5A5A5A) begin errors++; $display("FAIL bp_result got %h want 5a5a5a5a", bus.result); end
    retire();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_retire out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int bad = 0;
    issue(OP_SLL, 32'h00000001, 32'h0000000A);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_shift ov/ir got %b/%b want 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.result !== 32'h5A5A5A5A) begin errors++; $display("FAIL flush_shift_result got %h want 5a5a5a5a", bus.result); end
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flush_shift_quiet got %0d want 0", bad); end
    // accept suppressed by flush in the same cycle
    bus.flush = 1'b1;
    issue(OP_ADD, 32'h00000001, 32'h00000001);
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL flush_accept ov/state got %b/%0d want 0/0", bus.out_valid, dbg_state);
    end
    // flush beats out_ready and in_valid while DONE
    issue(OP_ADD, 32'h00000002, 32'h00000003);
    checks++;
    if (bus.result !== 32'h00000005 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_done_pre got %h/%b want 00000005/1", bus.result, bus.out_valid);
    end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    issue(OP_ADD, 32'h00000007, 32'h00000007);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h00000005 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL flush_done got ov=%b res=%h st=%0d want 0/00000005/0", bus.out_valid, bus.result, dbg_state);
    end
  endtask

  task automatic test_rst_mid_shift();
    int bad = 0;
    issue(OP_SRL, 32'hFFFFFFFF, 32'h00000014);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_mid ov=%b res=%h z=%b st=%0d want 0/00000000/0/0", bus.out_valid, bus.result, bus.zero, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d want 0", bad); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", bus.in_ready); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_arith();
    test_sra_long();
    test_shift();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
